// File: rtl/au_lead_sign_norm_pipe.sv
// Two-stage elastic leading-sign / leading-zero / leading-one detector and normaliser.
// Stage 1 registers the one-hot detect and encoded count; stage 2 registers the shifted word.
module au_lead_sign_norm_pipe #(
  parameter int WIDTH = 16,
  parameter int ARCH  = 0,
  localparam int CW   = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_cnt,
  output logic [WIDTH-1:0] out_norm,
  output logic             out_all
);

  logic             sign_mode;
  logic [WIDTH-2:0] diff;
  logic [WIDTH-1:0] vec;
  logic [WIDTH-1:0] zpre;
  logic [WIDTH-1:0] onehot;
  logic [CW-1:0]    cnt_enc;

  logic             s1_v, s2_v;
  logic             s1_ready, s2_ready;
  logic [WIDTH-1:0] s1_data;
  logic [1:0]       s1_mode;
  logic [WIDTH-1:0] s1_onehot;
  logic [CW-1:0]    s1_cnt;
  logic             s1_sign;
  logic [WIDTH-1:0] s2_norm_d;
  logic             s2_all_d;

  // Every mode reduces to a leading-zero count of vec. In sign mode the bits below
  // the MSB are compared to it and a sentinel 1 caps the count at WIDTH-1.
  always_comb begin
    sign_mode = (in_mode == 2'd0) || (in_mode == 2'd3);
    diff      = in_data[WIDTH-2:0] ^ {(WIDTH-1){in_data[WIDTH-1]}};
    if (sign_mode)
      vec = {diff, 1'b1};
    else if (in_mode == 2'd1)
      vec = in_data;
    else
      vec = ~in_data;
  end

  // zpre[i] = 1 when vec[WIDTH-1:i] is all zero
  generate
    if (ARCH == 1) begin : g_kogge
      logic [WIDTH-1:0] p, q;
      always_comb begin
        p = ~vec;
        q = p;
        for (int d = 1; d < WIDTH; d = d * 2) begin
          q = p;
          for (int i = 0; i + d < WIDTH; i++)
            p[i] = q[i] & q[i + d];
        end
        zpre = p;
      end
    end else if (ARCH == 2) begin : g_sklansky
      logic [WIDTH-1:0] q;
      always_comb begin
        q = '0;
        for (int j = 0; j < WIDTH; j++)
          q[j] = ~vec[WIDTH-1-j];
        for (int k = 0; (1 << k) < WIDTH; k++)
          for (int j = 0; j < WIDTH; j++)
            if (((j >> k) & 1) == 1)
              q[j] = q[j] & q[((j >> k) << k) - 1];
        zpre = '0;
        for (int j = 0; j < WIDTH; j++)
          zpre[WIDTH-1-j] = q[j];
      end
    end else begin : g_ripple
      logic [WIDTH-1:0] p;
      always_comb begin
        p = '0;
        p[WIDTH-1] = ~vec[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--)
          p[i] = p[i+1] & ~vec[i];
        zpre = p;
      end
    end
  endgenerate

  always_comb begin
    onehot  = '0;
    cnt_enc = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i == WIDTH - 1)
        onehot[i] = vec[i];
      else
        onehot[i] = vec[i] & zpre[i+1];
    end
    for (int i = 0; i < WIDTH; i++)
      if (onehot[i])
        cnt_enc = cnt_enc | CW'(WIDTH - 1 - i);
    if (zpre[0])
      cnt_enc = cnt_enc | CW'(WIDTH);
  end

  assign s2_ready = ~s2_v | out_ready;
  assign s1_ready = ~s1_v | s2_ready;
  assign in_ready = ~rst_n | s1_ready;
  assign out_valid = s2_v;

  // In sign mode only the sentinel can fire when every bit matches the MSB
  always_comb begin
    s1_sign   = (s1_mode == 2'd0) || (s1_mode == 2'd3);
    s2_norm_d = s1_data << s1_cnt;
    s2_all_d  = s1_sign ? s1_onehot[0] : ~|s1_onehot;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_v      <= 1'b0;
      s1_data   <= '0;
      s1_mode   <= '0;
      s1_onehot <= '0;
      s1_cnt    <= '0;
      s2_v      <= 1'b0;
      out_cnt   <= '0;
      out_norm  <= '0;
      out_all   <= 1'b0;
    end else begin
      if (s1_ready) begin
        s1_v <= in_valid;
        if (in_valid) begin
          s1_data   <= in_data;
          s1_mode   <= in_mode;
          s1_onehot <= onehot;
          s1_cnt    <= cnt_enc;
        end
      end
      if (s2_ready) begin
        s2_v <= s1_v;
        if (s1_v) begin
          out_cnt  <= s1_cnt;
          out_norm <= s2_norm_d;
          out_all  <= s2_all_d;
        end
      end
    end
  end

endmodule

// File: tb/tb_au_lead_sign_norm_pipe.sv
// Directed bench for au_lead_sign_norm_pipe: three WIDTH=8 instances (ARCH 0..2)
// share stimulus and are each checked against a hand-computed vector table.
module tb_au_lead_sign_norm_pipe;
  localparam int W  = 8;
  localparam int CW = 4;
  localparam int NA = 3;
  localparam int NV = 20;

  typedef struct {
    logic [1:0]   m;
    logic [W-1:0] d;
    int           c;
    logic [W-1:0] n;
    logic         a;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic [1:0]    in_mode = '0;
  logic [NA-1:0] ir, ov, oa;
  logic [CW-1:0] oc [NA];
  logic [W-1:0]  on [NA];

  vec_t tv [NV];
  int   nchk = 0;
  int   nerr = 0;
  int   cyc = 0;
  int   expq [$];
  int   accq [$];
  bit   lat_en = 1'b0;
  int   last_acc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  genvar g;
  generate
    for (g = 0; g < NA; g++) begin : g_dut
      au_lead_sign_norm_pipe #(.WIDTH(W), .ARCH(g)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(ir[g]), .in_data(in_data), .in_mode(in_mode),
        .out_valid(ov[g]), .out_ready(out_ready),
        .out_cnt(oc[g]), .out_norm(on[g]), .out_all(oa[g])
      );
    end
  endgenerate

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    for (int k = 0; k < NA; k++) begin
      chk($sformatf("%s valid a%0d", tag, k), ov[k], 0);
      chk($sformatf("%s cnt a%0d", tag, k), oc[k], 0);
      chk($sformatf("%s norm a%0d", tag, k), on[k], 0);
      chk($sformatf("%s all a%0d", tag, k), oa[k], 0);
      chk($sformatf("%s in_ready a%0d", tag, k), ir[k], 1);
    end
  endtask

  task automatic send(input int i);
    int n;
    bit acc;
    int cacc;
    in_valid = 1'b1;
    in_data  = tv[i].d;
    in_mode  = tv[i].m;
    n = 0;
    acc = 1'b0;
    cacc = 0;
    while (!acc && n < 40) begin
      @(negedge clk);
      acc  = &ir;
      cacc = cyc;
      @(posedge clk);
      n++;
    end
    #1 in_valid = 1'b0;
    chk($sformatf("accept v%0d", i), acc, 1);
    if (acc) begin
      expq.push_back(i);
      accq.push_back(cacc);
      last_acc = cacc;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (expq.size() > 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain", expq.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Output scoreboard: every transfer is matched in order against the accepted words
  always @(negedge clk) begin
    int i, a;
    if (rst_n && out_ready && (|ov)) begin
      chk("out_expected", (expq.size() > 0), 1);
      if (expq.size() > 0) begin
        i = expq.pop_front();
        a = accq.pop_front();
        for (int k = 0; k < NA; k++) begin
          chk($sformatf("v%0d valid a%0d", i, k), ov[k], 1);
          chk($sformatf("v%0d cnt a%0d", i, k), oc[k], tv[i].c);
          chk($sformatf("v%0d norm a%0d", i, k), on[k], tv[i].n);
          chk($sformatf("v%0d all a%0d", i, k), oa[k], tv[i].a);
        end
        if (lat_en) chk($sformatf("v%0d latency", i), cyc - a, 2);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    tv[0]  = '{2'd0, 8'h0A, 3, 8'h50, 1'b0};
    tv[1]  = '{2'd0, 8'hF5, 3, 8'hA8, 1'b0};
    tv[2]  = '{2'd0, 8'h00, 7, 8'h00, 1'b1};
    tv[3]  = '{2'd0, 8'hFF, 7, 8'h80, 1'b1};
    tv[4]  = '{2'd1, 8'h00, 8, 8'h00, 1'b1};
    tv[5]  = '{2'd2, 8'hFF, 8, 8'h00, 1'b1};
    tv[6]  = '{2'd1, 8'h80, 0, 8'h80, 1'b0};
    tv[7]  = '{2'd3, 8'h0A, 3, 8'h50, 1'b0};
    tv[8]  = '{2'd1, 8'h01, 7, 8'h80, 1'b0};
    tv[9]  = '{2'd1, 8'h02, 6, 8'h80, 1'b0};
    tv[10] = '{2'd1, 8'h04, 5, 8'h80, 1'b0};
    tv[11] = '{2'd1, 8'h08, 4, 8'h80, 1'b0};
    tv[12] = '{2'd2, 8'hE3, 3, 8'h18, 1'b0};
    tv[13] = '{2'd2, 8'h7F, 0, 8'h7F, 1'b0};
    tv[14] = '{2'd0, 8'h40, 0, 8'h40, 1'b0};
    tv[15] = '{2'd1, 8'h3C, 2, 8'hF0, 1'b0};
    tv[16] = '{2'd0, 8'hC1, 1, 8'h82, 1'b0};
    tv[17] = '{2'd2, 8'hFE, 7, 8'h00, 1'b0};
    tv[18] = '{2'd0, 8'h01, 6, 8'h40, 1'b0};
    tv[19] = '{2'd1, 8'h7F, 1, 8'hFE, 1'b0};

    // reset state
    rst_n = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_idle("in_reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk_idle("post_reset");
    @(posedge clk);
    #1;

    // first word: two-cycle latency
    lat_en = 1'b1;
    send(0);
    @(negedge clk);
    for (int k = 0; k < NA; k++) chk($sformatf("lat1 valid a%0d", k), ov[k], 0);
    @(negedge clk);
    for (int k = 0; k < NA; k++) chk($sformatf("lat2 valid a%0d", k), ov[k], 1);
    @(posedge clk);
    #1;

    // directed modes and boundaries, back to back
    for (int i = 1; i < 8; i++) send(i);

    // consecutive-cycle stream
    send(8);
    c0 = last_acc;
    for (int i = 9; i < 12; i++) send(i);
    chk("stream_tput", last_acc - c0, 3);
    drain();

    // back-pressure: out_ready low for 4 cycles while streaming
    lat_en = 1'b0;
    out_ready = 1'b0;
    fork
      begin
        for (int i = 12; i < 18; i++) send(i);
      end
      begin
        repeat (3) @(negedge clk);
        for (int k = 0; k < NA; k++) begin
          chk($sformatf("bp in_ready a%0d", k), ir[k], 0);
          chk($sformatf("bp valid a%0d", k), ov[k], 1);
          chk($sformatf("bp cnt a%0d", k), oc[k], 3);
          chk($sformatf("bp norm a%0d", k), on[k], 8'h18);
        end
        @(negedge clk);
        for (int k = 0; k < NA; k++) begin
          chk($sformatf("bp hold in_ready a%0d", k), ir[k], 0);
          chk($sformatf("bp hold cnt a%0d", k), oc[k], 3);
          chk($sformatf("bp hold norm a%0d", k), on[k], 8'h18);
          chk($sformatf("bp hold all a%0d", k), oa[k], 0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // reset with both stages full; word offered during reset must be dropped
    out_ready = 1'b0;
    send(18);
    send(19);
    @(negedge clk);
    for (int k = 0; k < NA; k++) begin
      chk($sformatf("full in_ready a%0d", k), ir[k], 0);
      chk($sformatf("full valid a%0d", k), ov[k], 1);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    in_valid = 1'b1;
    in_data = tv[0].d;
    in_mode = tv[0].m;
    @(negedge clk);
    for (int k = 0; k < NA; k++) chk($sformatf("rst in_ready a%0d", k), ir[k], 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    in_valid = 1'b0;
    expq.delete();
    accq.delete();
    out_ready = 1'b1;
    @(negedge clk);
    chk_idle("mid_reset");
    repeat (3) begin
      @(negedge clk);
      for (int k = 0; k < NA; k++) chk($sformatf("no_rst_word a%0d", k), ov[k], 0);
    end
    @(posedge clk);
    #1;
    lat_en = 1'b1;
    send(4);
    send(16);
    drain();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/au_lead_sign_norm_pipe.md
Name: au_lead_sign_norm_pipe

Overview:
Pipelined, handshaked leading-digit detector and normaliser for WIDTH-bit words. Each accepted word is counted in one of three runtime modes: redundant sign bits, leading zeros or leading ones. The block returns a binary count, the word left-shifted by that count, and an all-same flag. It feeds the normalisation front-end of the floating-point and block-scaling datapaths, replacing a combinational detector plus separate encoder and shifter.

Parameters:
WIDTH, 16, data word length (>= 2)
ARCH, 0, prefix-AND architecture used inside the detector (0 to 2); affects timing only, never results
CW, derived = ceil(log2(WIDTH+1)), count width (localparam, not overridable)

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  reset, synchronous, active-low
in_valid  input  1  input word valid
in_ready  output  1  block can accept input this cycle
in_data  input  WIDTH  word to analyse
in_mode  input  2  0 = leading signs, 1 = leading zeros, 2 = leading ones, 3 = treated as 0
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_cnt  output  CW  count (see Behaviour)
out_norm  output  WIDTH  in_data shifted left by out_cnt, zero-filled from LSB
out_all  output  1  input contained no terminating bit for the selected mode

Behaviour:
- Transfer occurs when valid & ready are both 1 on a clock edge, on both the input and the output side.
- Two-stage elastic pipeline:
  - S1 registers data, mode, one-hot detect and encoded count.
  - S2 registers the shifted word, count and flag.
  - Each stage has a valid bit and loads when it is empty or its contents move on in the same cycle.
  - out_valid = S2 valid.
  - in_ready = ~S1_valid | (S2 empty | out_ready). This is combinational from out_ready; no path exists from in_valid to in_ready.
- Latency is exactly 2 cycles from input transfer to out_valid when there is no back-pressure. Throughput is 1 word/cycle with out_ready held at 1.
- Back-pressure: while out_valid=1 & out_ready=0, out_cnt, out_norm and out_all hold stable. With both stages full, in_ready=0. No word is dropped or duplicated, and order is preserved.
- Mode 0 (leading signs):
  - cnt = number of bits below the MSB that equal the MSB before the first differing bit. Range 0..WIDTH-1.
  - If every bit equals the MSB, cnt = WIDTH-1 and out_all = 1.
- Mode 1 (leading zeros): cnt = zeros counted from the MSB, range 0..WIDTH. All-zero input gives cnt = WIDTH, out_norm = 0, out_all = 1.
- Mode 2 (leading ones): same as mode 1 with ones. All-ones input gives cnt = WIDTH, out_norm = 0, out_all = 1.
- Shift amount is cnt. A shift by WIDTH yields 0.
- Reset (rst_n=0 at an edge):
  - Both stage valid bits clear, so out_valid = 0.
  - out_cnt, out_norm and out_all read 0.
  - in_ready reads 1 during and after reset.
  - Words in flight are discarded; a word offered in the reset cycle is not accepted.
- Mode is captured together with its data word. Changing in_mode between words has no effect on words already accepted.

Test Plan:
- WIDTH=8, reset then mode0 in_data=0x0A, out_ready=1 -> 2 cycles later out_cnt=3, out_norm=0x50, out_all=0; mode0 0xF5 -> cnt=3, norm=0xA8, all=0.
- WIDTH=8 boundaries:
  - mode0 0x00 -> cnt=7, norm=0x00, all=1.
  - mode0 0xFF -> cnt=7, norm=0x80, all=1.
  - mode1 0x00 -> cnt=8, norm=0x00, all=1.
  - mode2 0xFF -> cnt=8, norm=0x00, all=1.
  - mode1 0x80 -> cnt=0, norm=0x80.
  - mode3 0x0A -> same as mode0.
- Back-to-back stream: 0x01,0x02,0x04,0x08 in mode1 on consecutive cycles -> outputs cnt=7,6,5,4 on consecutive cycles; norm=0x80 for each.
- Back-pressure: out_ready=0 for 4 cycles while streaming -> in_ready drops after 2 accepted words, out_* stable, no loss; release -> remaining results in order.
- Reset mid-stream with both stages full -> next cycle out_valid=0, outputs 0, in_ready=1; first post-reset word appears 2 cycles after acceptance.
- Random: 10k words, random modes, random out_ready -> every result matches a reference model (count, shift, flag) in order; run for ARCH=0,1,2 and WIDTH=2,8,33.
